// File: rtl/reg_dump_printer.sv
// reg_dump_printer: walks a register file through a debug read port and writes
// each register as one text row ("xNN: " label plus uppercase hex, MSB nibble
// first) into a character buffer. Start/busy/done handshake, write
// backpressure via char_ready, and abort.
module reg_dump_printer #(
    parameter int          WORD_SIZE  = 32,
    parameter int          NUM_REGS   = 32,
    parameter int          RIDX_W     = 5,
    parameter int          ADDR_WIDTH = 13,
    parameter int          ROW_STRIDE = 80,
    parameter int          BASE_ADDR  = 0,
    parameter int          LABEL_EN   = 1,
    parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [RIDX_W-1:0]     reg_sel,
    input  logic [WORD_SIZE-1:0]  reg_val,
    output logic                  char_write_en,
    output logic [ADDR_WIDTH-1:0] char_write_address,
    output logic [31:0]           char_data,
    input  logic                  char_ready
);

    localparam int DIGITS = WORD_SIZE / 4;
    localparam int LBL    = (LABEL_EN != 0) ? 5 : 0;
    localparam int CHARS  = DIGITS + LBL;
    localparam int COL_W  = $clog2(CHARS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LATCH,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [RIDX_W-1:0]       idx_q, idx_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [WORD_SIZE-1:0]    value_q, value_d;
    logic [RIDX_W-1:0]       reg_sel_q, reg_sel_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    char_write_en_q, char_write_en_d;
    logic [ADDR_WIDTH-1:0]   char_write_address_q, char_write_address_d;
    logic [31:0]             char_data_q, char_data_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

    // Character shown at column col of the row for register idx holding val.
    function automatic logic [7:0] char_at(input logic [RIDX_W-1:0]    idx,
                                           input logic [COL_W-1:0]     col,
                                           input logic [WORD_SIZE-1:0] val);
        logic [7:0]           idx8;
        logic [WORD_SIZE-1:0] sh;
        int                   nib;
        idx8 = 8'(idx);
        if (LABEL_EN != 0 && int'(col) < 5) begin
            case (int'(col))
                0:       return 8'h78;
                1:       return 8'h30 + idx8 / 8'd10;
                2:       return 8'h30 + idx8 % 8'd10;
                3:       return 8'h3A;
                default: return 8'h20;
            endcase
        end
        nib = DIGITS - 1 - (int'(col) - LBL);
        sh  = val >> (4 * nib);
        return hex_ascii(sh[3:0]);
    endfunction

    // Row/column to buffer address; anything above ADDR_WIDTH wraps silently.
    function automatic logic [ADDR_WIDTH-1:0] char_addr(input logic [RIDX_W-1:0] idx,
                                                        input logic [COL_W-1:0]  col);
        logic [31:0] a;
        a = 32'(BASE_ADDR) + 32'(idx) * 32'(ROW_STRIDE) + 32'(col);
        return a[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic is_busy(input state_t s);
        return (s == S_SELECT) || (s == S_LATCH) || (s == S_EMIT) || (s == S_NEXT);
    endfunction

    // Next-state sequencing, with outputs precomputed from the next state so they leave a flop.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        value_d   = value_q;
        reg_sel_d = reg_sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SELECT;
                    idx_d     = '0;
                    col_d     = '0;
                    reg_sel_d = '0;
                end
            end
            S_SELECT: begin
                col_d   = '0;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                value_d = reg_val;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (char_ready) begin
                    if (col_q == COL_W'(CHARS - 1)) state_d = S_NEXT;
                    else                             col_d   = col_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (idx_q == RIDX_W'(NUM_REGS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    reg_sel_d = idx_q + 1'b1;
                    col_d     = '0;
                    state_d   = S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && is_busy(state_q)) state_d = S_IDLE;

        busy_d               = is_busy(state_d);
        done_d               = (state_d == S_DONE);
        char_write_en_d      = (state_d == S_EMIT);
        char_write_address_d = char_write_en_d ? char_addr(idx_d, col_d) : '0;
        char_data_d          = char_write_en_d ? {char_at(idx_d, col_d, value_d), ATTR} : 32'h0;
    end

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q              <= S_IDLE;
            idx_q                <= '0;
            col_q                <= '0;
            value_q              <= '0;
            reg_sel_q            <= '0;
            busy_q               <= 1'b0;
            done_q               <= 1'b0;
            char_write_en_q      <= 1'b0;
            char_write_address_q <= '0;
            char_data_q          <= '0;
        end else begin
            state_q              <= state_d;
            idx_q                <= idx_d;
            col_q                <= col_d;
            value_q              <= value_d;
            reg_sel_q            <= reg_sel_d;
            busy_q               <= busy_d;
            done_q               <= done_d;
            char_write_en_q      <= char_write_en_d;
            char_write_address_q <= char_write_address_d;
            char_data_q          <= char_data_d;
        end
    end

    // Abort withdraws the pending write in its own cycle so the aborting edge
    // can never complete a transfer, even with char_ready high.
    assign char_write_en      = char_write_en_q & ~abort;
    assign busy               = busy_q;
    assign done               = done_q;
    assign reg_sel            = reg_sel_q;
    assign char_write_address = char_write_address_q;
    assign char_data          = char_data_q;

endmodule

// File: tb/tb_reg_dump_printer.sv
// Bench for reg_dump_printer: default instance (A) plus a 16-bit, 4-register,
// unlabelled instance (B) whose rows wrap past the top of the address space.
module tb_reg_dump_printer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, abort_a, ready_a;
    logic        abort_b = 1'b0;
    logic        ready_b = 1'b1;

    logic        busy_a, done_a, we_a;
    logic [4:0]  sel_a;
    logic [12:0] addr_a;
    logic [31:0] data_a, reg_val_a;
    logic [31:0] regs_a [32];

    logic        busy_b, done_b, we_b;
    logic [1:0]  sel_b;
    logic [12:0] addr_b;
    logic [31:0] data_b;
    logic [15:0] reg_val_b;
    logic [15:0] regs_b [4];

    assign reg_val_a = regs_a[sel_a];
    assign reg_val_b = regs_b[sel_b];

    reg_dump_printer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .reg_sel(sel_a), .reg_val(reg_val_a),
        .char_write_en(we_a), .char_write_address(addr_a), .char_data(data_a),
        .char_ready(ready_a)
    );

    reg_dump_printer #(
        .WORD_SIZE(16), .NUM_REGS(4), .RIDX_W(2), .ADDR_WIDTH(13),
        .ROW_STRIDE(80), .BASE_ADDR(8180), .LABEL_EN(0), .ATTR(24'hFFFFFF)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .reg_sel(sel_b), .reg_val(reg_val_b),
        .char_write_en(we_b), .char_write_address(addr_b), .char_data(data_b),
        .char_ready(ready_b)
    );

    int nvec = 0;
    int nerr = 0;
    logic [44:0] exp_a[$], got_a[$], exp_b[$], got_b[$];
    int busy_n, done_n, busyb_n, doneb_n, gap_bad, stall_bad;
    bit prev_busy, pend;
    logic [12:0] paddr;
    logic [31:0] pdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference rows: label text and uppercase hex built as strings.
    task automatic build_a();
        string s, h;
        logic [31:0] a;
        exp_a.delete();
        for (int i = 0; i < 32; i++) begin
            h = $sformatf("%08h", regs_a[i]);
            s = {$sformatf("x%02d: ", i), h.toupper()};
            for (int c = 0; c < 13; c++) begin
                a = (i * 80 + c) % 8192;
                exp_a.push_back({a[12:0], s[c], 24'hFFFFFF});
            end
        end
    endtask

    task automatic build_b();
        string h;
        logic [31:0] a;
        exp_b.delete();
        for (int i = 0; i < 4; i++) begin
            h = $sformatf("%04h", regs_b[i]);
            h = h.toupper();
            for (int c = 0; c < 4; c++) begin
                a = (8180 + i * 80 + c) % 8192;
                exp_b.push_back({a[12:0], h[c], 24'hFFFFFF});
            end
        end
    endtask

    task automatic compare(input string tag, input logic [44:0] got[$],
                           input logic [44:0] expq[$], input int n);
        check({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int k = 0; k < n && k < got.size(); k++)
            check($sformatf("%s[%0d]", tag, k), 64'(got[k]), 64'(expq[k]));
    endtask

    // mode 0: plain run (B too), 1: random char_ready, 2: abort at row 3 col 7,
    // 3: reset during a write, 4: extra start pulse while busy.
    task automatic run_dump(input int mode);
        bit aborted, exited;
        got_a.delete();
        got_b.delete();
        busy_n = 0; done_n = 0; busyb_n = 0; doneb_n = 0;
        gap_bad = 0; stall_bad = 0; prev_busy = 0; pend = 0; exited = 0;
        @(negedge clk);
        start_a = 1'b1; start_b = (mode == 0); ready_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        for (int cyc = 0; cyc < 3000 && !exited; cyc++) begin
            ready_a = (mode == 1) ? ($urandom_range(0, 4) < 2) : 1'b1;
            start_a = (mode == 4 && cyc == 100);
            #1;
            aborted = 0;
            if (mode == 2 && we_a && addr_a == 13'd247) begin
                abort_a = 1'b1;
                #1;
                check("abort_write_withdrawn", we_a, 0);
                aborted = 1;
            end
            if (mode == 3 && cyc >= 200 && we_a) begin
                rst = 1'b0;
                #1;
                check("rst_busy", busy_a, 0);
                check("rst_done", done_a, 0);
                check("rst_we", we_a, 0);
                check("rst_addr", addr_a, 0);
                check("rst_data", data_a, 0);
                check("rst_sel", sel_a, 0);
                @(negedge clk);
                rst = 1'b1;
                repeat (3) @(negedge clk);
                check("post_rst_busy", busy_a, 0);
                check("post_rst_we", we_a, 0);
                exited = 1;
            end else begin
                if (busy_a) busy_n++;
                if (done_a) begin
                    done_n++;
                    if (!prev_busy) gap_bad++;
                end
                if (pend && !(we_a && addr_a == paddr && data_a == pdata)) stall_bad++;
                pend  = we_a && !ready_a;
                paddr = addr_a;
                pdata = data_a;
                if (we_a && ready_a) begin
                    got_a.push_back({addr_a, data_a});
                    regs_a[sel_a] = $urandom;
                end
                if (busy_b) busyb_n++;
                if (done_b) doneb_n++;
                if (we_b && ready_b) got_b.push_back({addr_b, data_b});
                prev_busy = busy_a;
                if (aborted) begin
                    @(negedge clk);
                    abort_a = 1'b0;
                    check("abort_busy", busy_a, 0);
                    check("abort_we", we_a, 0);
                    repeat (20) begin
                        @(negedge clk);
                        if (done_a) done_n++;
                        if (we_a) got_a.push_back({addr_a, data_a});
                    end
                    exited = 1;
                end else if (done_n > 0 && !done_a) begin
                    exited = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        check("run_terminated", 64'(exited), 1);
    endtask

    initial begin
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        for (int i = 0; i < 32; i++) regs_a[i] = $urandom;
        regs_a[5] = 32'hDEADBEEF;
        regs_b[0] = 16'h0000; regs_b[1] = 16'hFFFF;
        regs_b[2] = 16'h1234; regs_b[3] = 16'hA0B1;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_we", we_a, 0);
        check("reset_addr", addr_a, 0);
        check("reset_data", data_a, 0);
        check("reset_sel", sel_a, 0);
        check("reset_b_busy", busy_b, 0);
        rst = 1'b1;

        build_a();
        build_b();
        run_dump(0);
        compare("full_dump", got_a, exp_a, 416);
        check("busy_cycles", busy_n, 512);
        check("done_pulses", done_n, 1);
        check("done_after_busy", gap_bad, 0);
        compare("narrow_dump", got_b, exp_b, 16);
        check("narrow_busy_cycles", busyb_n, 28);
        check("narrow_done_pulses", doneb_n, 1);

        build_a();
        run_dump(1);
        compare("stall_dump", got_a, exp_a, 416);
        check("stall_hold", stall_bad, 0);
        check("stall_done_pulses", done_n, 1);
        check("stall_done_after_busy", gap_bad, 0);

        build_a();
        run_dump(2);
        compare("abort_prefix", got_a, exp_a, 46);
        check("abort_no_done", done_n, 0);

        build_a();
        run_dump(4);
        compare("restart_dump", got_a, exp_a, 416);
        check("restart_busy_cycles", busy_n, 512);
        check("restart_done_pulses", done_n, 1);

        run_dump(3);

        build_a();
        run_dump(1);
        compare("after_reset_dump", got_a, exp_a, 416);
        check("after_reset_stall_hold", stall_bad, 0);
        check("after_reset_done_pulses", done_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
